if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage LoongArch pipeline; the producer side of the IF→ID interface.
- Generates the PC and fetches each instruction over an sram-like request/response port.
- Hands {inst, pc} to the decode stage with a valid/allowin handshake.
- Consumes the decode stage's branch bus and cancels wrong-path fetches.

---
 rtl/if_stage.sv | 135 +++++++++++++
 tb/tb_if_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: generates the PC and fetches over an sram-like port with one request
// in flight. It hands {inst, pc} to decode and redirects on decode's branch bus.
module if_stage #(
  parameter logic [31:0]  RESET_PC        = 32'h1c000000,
  localparam int unsigned BR_BUS_WD       = 33,
  localparam int unsigned FS_TO_DS_BUS_WD = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [3:0]                 inst_sram_wstrb,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [31:0] req_addr;
  logic [31:0] seq_pc;
  logic        br_pend;
  logic [31:0] br_pend_target;
  logic        br_seen;
  logic        stale;
  logic        cancel;
  logic [31:0] inst_r;
  logic [31:0] pc_r;

  logic        br_taken;
  logic [31:0] br_target;
  logic        br_ev;
  logic        handoff;
  logic [31:0] next_addr;

  assign {br_taken, br_target} = br_bus;

  // A held-stable branch redirects only once: br_seen masks it until it leaves decode.
  assign br_ev   = br_taken & ~br_seen;
  assign handoff = fs_to_ds_valid & ds_allowin;

  always_comb begin
    next_addr = seq_pc + 32'd4;
    if (br_ev) begin
      next_addr = br_target;
    end else if (br_pend) begin
      next_addr = br_pend_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_REQ;
      req_addr       <= RESET_PC;
      seq_pc         <= RESET_PC - 32'd4;
      br_pend        <= 1'b0;
      br_pend_target <= 32'd0;
      br_seen        <= 1'b0;
      stale          <= 1'b0;
      cancel         <= 1'b0;
      inst_r         <= 32'd0;
      pc_r           <= 32'd0;
    end else begin
      if (br_ev) begin
        br_seen <= 1'b1;
      end else if (handoff || !br_taken) begin
        br_seen <= 1'b0;
      end

      case (state)
        S_REQ: begin
          if (inst_sram_addr_ok) begin
            state  <= S_WAIT;
            seq_pc <= req_addr;
            cancel <= stale | br_ev;
            stale  <= 1'b0;
            if (br_ev) begin
              br_pend        <= 1'b1;
              br_pend_target <= br_target;
            end
          end else if (br_ev) begin
            // The address must not move while unaccepted; redirect after the stale fetch.
            stale          <= 1'b1;
            br_pend        <= 1'b1;
            br_pend_target <= br_target;
          end
        end
        S_WAIT: begin
          if (inst_sram_data_ok) begin
            if (cancel || br_ev) begin
              state    <= S_REQ;
              req_addr <= next_addr;
              br_pend  <= 1'b0;
              cancel   <= 1'b0;
            end else begin
              state  <= S_HOLD;
              inst_r <= inst_sram_rdata;
              pc_r   <= seq_pc;
            end
          end else if (br_ev) begin
            cancel         <= 1'b1;
            br_pend        <= 1'b1;
            br_pend_target <= br_target;
          end
        end
        S_HOLD: begin
          if (br_ev || handoff) begin
            state    <= S_REQ;
            req_addr <= next_addr;
            br_pend  <= 1'b0;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign fs_to_ds_valid  = (state == S_HOLD) & ~br_ev;
  assign fs_to_ds_bus    = {inst_r, pc_r};
  assign inst_sram_req   = (state == S_REQ) & ~reset;
  assign inst_sram_addr  = req_addr;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: sram and decode-stage models around the DUT, with an architectural
// program-flow model predicting every handed-off {inst, pc}.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  // Memory image: a bijection of the address, so a wrong pc/inst pairing is visible.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a3c96e1;
  endfunction

  // sram model
  bit          s_busy;
  logic [31:0] s_addr;
  int          s_dly, lat, aok_pct, blk_cnt, blk_seen;
  logic [31:0] blk_addr;
  // decode model
  bit          d_valid, d_br, rnd_mode;
  logic [31:0] d_tgt;
  int          d_delay, d_cnt, d_age, br_pct;
  logic [31:0] plan_tgt [logic [31:0]];
  int          plan_dly [logic [31:0]];
  int          plan_stall [logic [31:0]];
  // observation
  logic [31:0] addr_log[$], pc_log[$];
  int          ho_cyc[$];
  logic [31:0] exp_pc, prev_addr;
  logic [63:0] prev_bus;
  int          cyc_n, hold_stall;
  bit          prev_pend, prev_stall;
  logic        valid_at_br;

  function automatic logic [31:0] alog(input int i);
    return (i < addr_log.size()) ? addr_log[i] : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] plog(input int i);
    return (i < pc_log.size()) ? pc_log[i] : 32'hxxxxxxxx;
  endfunction
  function automatic int hlog(input int i);
    return (i < ho_cyc.size()) ? ho_cyc[i] : -1;
  endfunction

  // One clock: drive at the negedge, observe what the coming posedge will capture.
  task automatic cyc();
    bit aok, dok, ho;
    br_bus = {d_valid && d_br && d_age >= d_delay, (d_valid && d_br) ? d_tgt : 32'($urandom)};
    ds_allowin = !d_valid || d_cnt == 0;
    #1;
    dok = !reset && s_busy && s_dly == 0;
    aok = !reset && !s_busy && inst_sram_req && (int'($urandom_range(99)) < aok_pct);
    if (!reset && inst_sram_req && inst_sram_addr == blk_addr) begin
      blk_seen++;
      if (blk_cnt > 0) begin
        aok = 1'b0;
        blk_cnt--;
      end
    end
    inst_sram_addr_ok = aok;
    inst_sram_data_ok = dok;
    inst_sram_rdata = dok ? mem_word(s_addr) : 32'($urandom);
    #1;
    if (!reset) begin
      if (inst_sram_req) begin
        total++;
        if (s_busy) begin
          bad++; $display("FAIL one_outstanding: req=1 with a request in flight, required req=0");
        end
        total++;
        if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== {1'b0, 2'd2, 4'd0, 32'd0}) begin
          bad++; $display("FAIL sram_consts: wr=%b size=%0d wstrb=%h wdata=%h, required 0/2/0/0",
                          inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
        end
        if (prev_pend) begin
          total++;
          if (inst_sram_addr !== prev_addr) begin
            bad++; $display("FAIL addr_hold: addr=%h, required %h", inst_sram_addr, prev_addr);
          end
        end
      end
      if (fs_to_ds_valid === 1'b1) begin
        total++;
        if (inst_sram_req !== 1'b0) begin
          bad++; $display("FAIL req_in_hold: req=%b, required 0", inst_sram_req);
        end
        if (prev_stall) begin
          total++;
          if (fs_to_ds_bus !== prev_bus) begin
            bad++; $display("FAIL bus_stable: bus=%h, required %h", fs_to_ds_bus, prev_bus);
          end
        end
        if (!ds_allowin) hold_stall++;
      end
      if (d_valid && d_br && d_age == d_delay) valid_at_br = fs_to_ds_valid;

      ho = fs_to_ds_valid === 1'b1 && ds_allowin;
      if (ho) begin
        total++;
        if (fs_to_ds_bus[31:0] !== exp_pc) begin
          bad++; $display("FAIL handoff_pc: pc=%h, required %h", fs_to_ds_bus[31:0], exp_pc);
        end
        total++;
        if (fs_to_ds_bus[63:32] !== mem_word(exp_pc)) begin
          bad++; $display("FAIL handoff_inst: inst=%h, required %h", fs_to_ds_bus[63:32], mem_word(exp_pc));
        end
        pc_log.push_back(fs_to_ds_bus[31:0]);
        ho_cyc.push_back(cyc_n);
      end

      if (inst_sram_req && aok) begin
        s_busy = 1'b1;
        s_addr = inst_sram_addr;
        s_dly = (lat < 0) ? int'($urandom_range(3)) : lat;
        addr_log.push_back(inst_sram_addr);
      end else if (dok) begin
        s_busy = 1'b0;
      end else if (s_busy && s_dly > 0) begin
        s_dly--;
      end
      prev_pend = inst_sram_req && !aok;
      prev_addr = inst_sram_addr;
      prev_stall = fs_to_ds_valid === 1'b1 && !ds_allowin;
      prev_bus = fs_to_ds_bus;

      // Decode slot: the accepted instruction decides the architectural next pc.
      if (ho) begin
        d_valid = 1'b1;
        d_age = 0;
        if (rnd_mode) begin
          d_br = int'($urandom_range(99)) < br_pct;
          d_delay = d_br ? int'($urandom_range(2)) : 0;
          d_cnt = d_delay + int'($urandom_range(3));
          d_tgt = RESET_PC + ($urandom_range(4095) << 2);
        end else begin
          d_br = plan_tgt.exists(exp_pc);
          d_tgt = d_br ? plan_tgt[exp_pc] : 32'd0;
          d_delay = plan_dly.exists(exp_pc) ? plan_dly[exp_pc] : 0;
          d_cnt = plan_stall.exists(exp_pc) ? plan_stall[exp_pc] : 0;
        end
        exp_pc = d_br ? d_tgt : exp_pc + 32'd4;
      end else if (d_valid) begin
        if (d_cnt == 0) d_valid = 1'b0;
        else begin
          d_cnt--;
          d_age++;
        end
      end
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_busy = 1'b0; d_valid = 1'b0; d_br = 1'b0; d_cnt = 0; d_age = 0; d_delay = 0;
    rnd_mode = 1'b0; lat = 0; aok_pct = 100; br_pct = 0;
    blk_addr = 32'hffffffff; blk_cnt = 0; blk_seen = 0; hold_stall = 0;
    plan_tgt.delete(); plan_dly.delete(); plan_stall.delete();
    run(2);
    addr_log.delete(); pc_log.delete(); ho_cyc.delete();
    exp_pc = RESET_PC; cyc_n = 0; prev_pend = 1'b0; prev_stall = 1'b0; valid_at_br = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: req=%b valid=%b, required 0/0", inst_sram_req, fs_to_ds_valid);
    end
    reset = 1'b0;
    #1;
    total++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC) begin
      bad++; $display("FAIL first_req: req=%b addr=%h, required 1/%h", inst_sram_req, inst_sram_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    do_reset(); reset = 1'b0;
    run(12);
    total++;
    if (alog(0) !== 32'h1c000000 || alog(1) !== 32'h1c000004 || alog(2) !== 32'h1c000008) begin
      bad++; $display("FAIL seq_addrs: %h %h %h, required 1c000000 1c000004 1c000008", alog(0), alog(1), alog(2));
    end
    total++;
    if (hlog(0) != 2 || hlog(1) != 5 || hlog(2) != 8) begin
      bad++; $display("FAIL seq_timing: handoff cycles %0d %0d %0d, required 2 5 8", hlog(0), hlog(1), hlog(2));
    end
  endtask

  task automatic test_stall();
    do_reset(); reset = 1'b0;
    plan_stall[RESET_PC] = 8;
    run(20);
    total++;
    if (hold_stall < 5) begin
      bad++; $display("FAIL stall_hold: held %0d cycles, required at least 5", hold_stall);
    end
    total++;
    if (plog(1) !== 32'h1c000004 || hlog(1) != 11) begin
      bad++; $display("FAIL stall_release: pc=%h cycle=%0d, required 1c000004 at 11", plog(1), hlog(1));
    end
    total++;
    if (alog(2) !== 32'h1c000008) begin
      bad++; $display("FAIL stall_next_req: %h, required 1c000008", alog(2));
    end
  endtask

  task automatic test_branch_hold();
    do_reset(); reset = 1'b0;
    plan_tgt[32'h1c000004] = 32'h1c000100; plan_dly[32'h1c000004] = 2; plan_stall[32'h1c000004] = 2;
    run(20);
    total++;
    if (valid_at_br !== 1'b0) begin
      bad++; $display("FAIL br_hold_valid: valid=%b when branch raised, required 0", valid_at_br);
    end
    total++;
    if (alog(2) !== 32'h1c000008 || alog(3) !== 32'h1c000100) begin
      bad++; $display("FAIL br_hold_addrs: %h %h, required 1c000008 1c000100", alog(2), alog(3));
    end
    total++;
    if (plog(2) !== 32'h1c000100 || plog(3) !== 32'h1c000104) begin
      bad++; $display("FAIL br_hold_pcs: %h %h, required 1c000100 1c000104", plog(2), plog(3));
    end
  endtask

  task automatic test_branch_wait();
    do_reset(); reset = 1'b0;
    lat = 2;
    plan_tgt[RESET_PC] = 32'h1c000200; plan_dly[RESET_PC] = 1; plan_stall[RESET_PC] = 3;
    run(25);
    total++;
    if (alog(1) !== 32'h1c000004 || alog(2) !== 32'h1c000200) begin
      bad++; $display("FAIL br_wait_addrs: %h %h, required 1c000004 1c000200", alog(1), alog(2));
    end
    total++;
    if (plog(1) !== 32'h1c000200) begin
      bad++; $display("FAIL br_wait_pc: %h, required 1c000200", plog(1));
    end
  endtask

  task automatic test_branch_req();
    do_reset(); reset = 1'b0;
    plan_tgt[RESET_PC] = 32'h1c000200;
    blk_addr = 32'h1c000004; blk_cnt = 2;
    run(16);
    total++;
    if (blk_seen != 3) begin
      bad++; $display("FAIL br_req_held: addr 1c000004 presented %0d cycles, required 3", blk_seen);
    end
    total++;
    if (alog(1) !== 32'h1c000004 || alog(2) !== 32'h1c000200) begin
      bad++; $display("FAIL br_req_addrs: %h %h, required 1c000004 1c000200", alog(1), alog(2));
    end
    total++;
    if (plog(1) !== 32'h1c000200) begin
      bad++; $display("FAIL br_req_pc: %h, required 1c000200", plog(1));
    end
  endtask

  task automatic test_back_to_back_branch();
    do_reset(); reset = 1'b0;
    plan_tgt[RESET_PC] = 32'h1c000200; plan_stall[RESET_PC] = 4;
    plan_tgt[32'h1c000200] = 32'h1c000300;
    run(20);
    total++;
    if (alog(2) !== 32'h1c000200 || alog(3) !== 32'h1c000204 || alog(4) !== 32'h1c000300) begin
      bad++; $display("FAIL b2b_addrs: %h %h %h, required 1c000200 1c000204 1c000300", alog(2), alog(3), alog(4));
    end
    total++;
    if (plog(1) !== 32'h1c000200 || plog(2) !== 32'h1c000300) begin
      bad++; $display("FAIL b2b_pcs: %h %h, required 1c000200 1c000300", plog(1), plog(2));
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset(); reset = 1'b0;
    lat = 6;
    run(3);
    do_reset(); reset = 1'b0;
    run(8);
    total++;
    if (alog(0) !== RESET_PC || plog(0) !== RESET_PC || hlog(0) != 2) begin
      bad++; $display("FAIL reset_wait: addr=%h pc=%h cycle=%0d, required %h %h 2", alog(0), plog(0), hlog(0), RESET_PC, RESET_PC);
    end
  endtask

  task automatic test_random();
    do_reset(); reset = 1'b0;
    rnd_mode = 1'b1; lat = -1; aok_pct = 70; br_pct = 30;
    run(3000);
    total++;
    if (pc_log.size() < 100) begin
      bad++; $display("FAIL random_progress: %0d handoffs, required at least 100", pc_log.size());
    end
  endtask

  initial begin
    reset = 1'b1; ds_allowin = 1'b1; br_bus = '0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_branch_hold();
    test_branch_wait();
    test_branch_req();
    test_back_to_back_branch();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
